// File: rtl/prediction_residual_nl.sv
// JPEG-LS prediction residual: bias-corrected prediction error, NEAR quantisation
// through an iterative restoring divider, then modulo-RANGE reduction. One sample in flight.
module prediction_residual_nl #(
    parameter int pixel_length    = 8,
    parameter int C_length        = 9,
    parameter int mode_length     = 2,
    parameter int residual_length = pixel_length + 1,
    parameter int NEAR_length     = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [pixel_length-1:0]           x,
    input  logic [pixel_length-1:0]           Px,
    input  logic signed [C_length-1:0]        C,
    input  logic                              sign,
    input  logic [mode_length-1:0]            mode,
    input  logic                              RIType,
    input  logic                              a_b_compare,
    input  logic [NEAR_length-1:0]            near,
    input  logic [pixel_length:0]             range,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [residual_length-1:0]        x_residual
);
    // state  | meaning
    // S_IDLE | waiting for a sample, in_ready high
    // S_PRED | corrected prediction and Errval
    // S_DIV  | NEAR quantisation, one quotient bit per cycle
    // S_MOD  | modulo-RANGE reduction into x_residual
    // S_OUT  | residual presented until out_ready
    typedef enum logic [2:0] {S_IDLE, S_PRED, S_DIV, S_MOD, S_OUT} state_t;

    localparam int EW = pixel_length + 3;
    localparam int DW = pixel_length + 1;
    localparam int RW = NEAR_length + 1;
    localparam int CW = $clog2(DW + 1);
    localparam logic signed [EW-1:0] MAXVAL = EW'((1 << pixel_length) - 1);

    state_t r_state, w_state_next;

    logic [pixel_length-1:0]    r_x, r_px;
    logic signed [C_length-1:0] r_c;
    logic                       r_sign, r_ri, r_ritype, r_abc, r_neg;
    logic [NEAR_length-1:0]     r_near;
    logic [pixel_length:0]      r_range;
    logic signed [EW-1:0]       r_err;
    logic [DW-1:0]              r_quo;
    logic [RW-1:0]              r_rem;
    logic [CW-1:0]              r_cnt;

    logic signed [EW-1:0] w_x_s, w_px_s, w_c_s, w_pc_raw, w_pc;
    logic signed [EW-1:0] w_e_reg, w_e_ri, w_e, w_abs, w_q_s, w_q_signed;
    logic signed [EW-1:0] w_half, w_m1, w_m2;
    logic [DW-1:0]        w_dividend, w_quo_next;
    logic [RW-1:0]        w_divisor, w_rem_next;
    logic [RW:0]          w_trial;
    logic                 w_ge;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);

    assign w_x_s    = EW'(r_x);
    assign w_px_s   = EW'(r_px);
    assign w_c_s    = EW'(r_c);
    assign w_pc_raw = r_sign ? (w_px_s - w_c_s) : (w_px_s + w_c_s);
    assign w_pc     = w_pc_raw[EW-1] ? '0 : ((w_pc_raw > MAXVAL) ? MAXVAL : w_pc_raw);
    assign w_e_reg  = r_sign ? (w_pc - w_x_s) : (w_x_s - w_pc);
    assign w_e_ri   = (!r_ritype && r_abc) ? (w_px_s - w_x_s) : (w_x_s - w_px_s);
    assign w_e      = r_ri ? w_e_ri : w_e_reg;
    assign w_abs    = w_e[EW-1] ? -w_e : w_e;
    // |e| + near always fits in pixel_length+1 bits for any 4-bit NEAR.
    assign w_dividend = DW'(w_abs + EW'(r_near));

    // Restoring step: the remainder stays below the divisor, so RW bits suffice.
    assign w_divisor  = {r_near, 1'b1};
    assign w_trial    = {r_rem, r_quo[DW-1]};
    assign w_ge       = (w_trial >= {1'b0, w_divisor});
    assign w_rem_next = w_ge ? RW'(w_trial - {1'b0, w_divisor}) : w_trial[RW-1:0];
    assign w_quo_next = {r_quo[DW-2:0], w_ge};
    assign w_q_s      = EW'(w_quo_next);
    assign w_q_signed = r_neg ? -w_q_s : w_q_s;

    assign w_half = EW'(r_range >> 1) + EW'(r_range[0]);
    assign w_m1   = r_err[EW-1] ? (r_err + EW'(r_range)) : r_err;
    assign w_m2   = (w_m1 >= w_half) ? (w_m1 - EW'(r_range)) : w_m1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_PRED;
            S_PRED:  w_state_next = (r_near == '0) ? S_MOD : S_DIV;
            S_DIV:   if (r_cnt == '0) w_state_next = S_MOD;
            S_MOD:   w_state_next = S_OUT;
            S_OUT:   if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= '0;
            r_px       <= '0;
            r_c        <= '0;
            r_sign     <= 1'b0;
            r_ri       <= 1'b0;
            r_ritype   <= 1'b0;
            r_abc      <= 1'b0;
            r_near     <= '0;
            r_range    <= '0;
            r_err      <= '0;
            r_neg      <= 1'b0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            x_residual <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_x      <= x;
                    r_px     <= Px;
                    r_c      <= C;
                    r_sign   <= sign;
                    r_ri     <= (mode == mode_length'(1));
                    r_ritype <= RIType;
                    r_abc    <= a_b_compare;
                    r_near   <= near;
                    r_range  <= range;
                end
                S_PRED: begin
                    r_err <= w_e;
                    r_neg <= w_e[EW-1];
                    r_quo <= w_dividend;
                    r_rem <= '0;
                    r_cnt <= CW'(DW - 1);
                end
                S_DIV: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) r_err <= w_q_signed;
                end
                S_MOD:   x_residual <= residual_length'(w_m2);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prediction_residual_nl.sv
// Directed bench for prediction_residual_nl: hand-computed residuals, latency,
// backpressure hold and asynchronous reset in the middle of a division.
module tb_prediction_residual_nl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = '0, Px = '0;
    logic signed [8:0] C = '0;
    logic       sign = 1'b0;
    logic [1:0] mode = '0;
    logic       RIType = 1'b0, a_b_compare = 1'b0;
    logic [3:0] near = '0;
    logic [8:0] range = 9'd256;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] x_residual;

    int n_checks = 0;
    int n_fail   = 0;

    prediction_residual_nl dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .Px(Px), .C(C), .sign(sign), .mode(mode), .RIType(RIType),
        .a_b_compare(a_b_compare), .near(near), .range(range),
        .out_valid(out_valid), .out_ready(out_ready), .x_residual(x_residual)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one sample, check busy flags, latency and residual; hold OUT for 'hold' cycles.
    task automatic run_sample(input string tag, input int nr, input int rg, input int md,
                              input int rit, input int abc, input int px, input int cc,
                              input int sg, input int xx, input int exp_res, input int hold);
        logic [8:0] e9;
        logic [8:0] held;
        int lat;
        int exp_lat;
        e9      = exp_res[8:0];
        exp_lat = (nr == 0) ? 2 : 11;
        near = nr[3:0]; range = rg[8:0]; mode = md[1:0]; RIType = rit[0];
        a_b_compare = abc[0]; Px = px[7:0]; C = cc[8:0]; sign = sg[0]; x = xx[7:0];
        out_ready = (hold == 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // scramble inputs: only the accept-cycle values may matter
        x = 8'hA5; Px = 8'h3C; C = 9'h0F0; sign = ~sign; mode = 2'd1; near = 4'd7; range = 9'd9;
        check_eq({tag, "_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid) check_eq({tag, "_busy_mid"}, in_ready, 0);
        end
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, x_residual, e9);
        held = x_residual;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, out_valid, 1);
            check_eq({tag, "_hold_res"}, x_residual, e9);
            check_eq({tag, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, "_idle_rdy"}, in_ready, 1);
        check_eq({tag, "_idle_valid"}, out_valid, 0);
        check_eq({tag, "_idle_res"}, x_residual, held);
    endtask

    initial begin
        #2;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_residual", x_residual, 0);
        #20 reset_n = 1'b1;
        @(posedge clk); #1;

        //          tag          near rng mode rit abc  Px   C  sgn  x   exp  hold
        run_sample("lossless",    0, 256, 0,   0,  0, 100,  5,  0, 110,   5, 0);
        run_sample("neg_corr",    0, 256, 0,   0,  0, 100,  5,  1,  90,   5, 0);
        run_sample("wrap",        0, 256, 0,   0,  0,  10,  0,  0, 250, -16, 0);
        run_sample("clamp_hi",    0, 256, 0,   0,  0, 250, 20,  0, 255,   0, 0);
        run_sample("clamp_lo",    0, 256, 0,   0,  0,   3,-10,  0,   0,   0, 0);
        run_sample("near_pos",    2,  52, 0,   0,  0, 100,  0,  0, 113,   3, 0);
        run_sample("near_neg",    2,  52, 0,   0,  0, 100,  0,  0,  87,  -3, 0);
        run_sample("ri_negate",   0, 256, 1,   0,  1,  50, 20,  1,  40,  10, 0);
        run_sample("ri_type1",    0, 256, 1,   1,  1,  50,  0,  0,  40, -10, 0);
        run_sample("ri_abc0",     0, 256, 1,   0,  0,  50,  0,  0,  40, -10, 0);
        run_sample("mode2_reg",   0, 256, 2,   0,  1, 100,  5,  0, 110,   5, 0);
        run_sample("near1_max",   1,  86, 0,   0,  0,   0,  0,  0, 255,  -1, 0);
        run_sample("backpress",   0, 256, 0,   0,  0, 100,  5,  0, 110,   5, 5);

        // Reset in DIV cycle 4 of a near-lossless sample
        near = 4'd2; range = 9'd52; mode = 2'd0; Px = 8'd100; C = '0; sign = 1'b0; x = 8'd113;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("div_busy", in_ready, 0);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_residual", x_residual, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("post_rst_idle_valid", out_valid, 0);
            check_eq("post_rst_idle_rdy", in_ready, 1);
        end
        run_sample("after_rst",   0, 256, 0,   0,  0, 100,  5,  0, 110,   5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prediction_residual_nl.md
Name: prediction_residual_nl

Overview:
- Sequential, handshaked successor to the combinational prediction-residual stage of the JPEG-LS encoder.
- Sits between the predictor/context stage and the Golomb/modulo coding stage.
- Accepts one sample (x, Px, C, sign, mode, RIType, a_b_compare) per transaction and computes the JPEG-LS prediction error.
- Adds near-lossless quantisation (runtime NEAR), implemented with an iterative divider, then modulo-RANGE reduction.

Parameters:
- pixel_length, 8, bits per sample; MAXVAL = 2^pixel_length - 1.
- C_length, 9, signed bias-correction width (two's complement).
- mode_length, 2, mode field width.
- residual_length, pixel_length+1, signed residual width.
- NEAR_length, 4, width of the near input.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- x  in  pixel_length  current sample
- Px  in  pixel_length  prediction; in run-interruption mode it is already Ra or Rb
- C  in  C_length  signed context bias correction
- sign  in  1  context sign
- mode  in  mode_length  0 = regular, 1 = run interruption, other values = regular
- RIType  in  1  run-interruption type
- a_b_compare  in  1  1 when Ra > Rb
- near  in  NEAR_length  NEAR value; 0 = lossless
- range  in  pixel_length+1  RANGE for this near (256 when near=0 at 8 bits)
- out_valid  out  1  residual valid
- out_ready  in  1  downstream accepts
- x_residual  out  residual_length  signed residual after modulo reduction

Behaviour:
- Reset: reset_n low forces, asynchronously:
  - state = IDLE
  - in_ready = 1, out_valid = 0, x_residual = 0
  - divider registers cleared
  - Applies in any state, including mid-division. After release the block is in IDLE with no residual pending.
- States: IDLE, PRED, DIV, MOD, OUT.
  - in_ready = (state == IDLE); out_valid = (state == OUT).
- IDLE: on in_valid & in_ready, latch all inputs, go to PRED. Otherwise stay.
- PRED (1 cycle): compute Errval and register it.
  - Regular mode:
    - Pc = Px + C if sign = 0, Px - C if sign = 1.
    - Clamp Pc to [0, MAXVAL].
    - e = x - Pc; negate e if sign = 1.
  - Run-interruption mode:
    - e = x - Px.
    - Negate e if RIType = 0 and a_b_compare = 1. C and sign are ignored.
  - Internal arithmetic is at least pixel_length+2 bits, so nothing overflows before the clamp.
  - Next state: MOD if near = 0, else DIV.
- DIV (exactly pixel_length+1 cycles): restoring division producing q = floor((|e| + near) / (2*near + 1)), one quotient bit per cycle, MSB first.
  - Cycle count is fixed and independent of the operand values.
  - Then e = -q if the original e < 0, else q. Go to MOD.
- MOD (1 cycle):
  - If e < 0, e = e + range.
  - Then if e >= (range + 1) >> 1, e = e - range.
  - Register x_residual = e, truncated to residual_length. Go to OUT.
- OUT: hold x_residual and out_valid stable until out_ready = 1. On the handshake edge go to IDLE.
  - out_ready may be high before OUT; the transfer happens on the first OUT cycle.
  - x_residual keeps its last value in IDLE.
- Latency: with the accepting edge as E, out_valid is first high after edge E+2 when near = 0, and after edge E+2+(pixel_length+1) when near > 0.
- Throughput: the next accept occurs no earlier than the edge after the output handshake. No overlap between samples.
- Inputs other than in_valid are don't-care outside the accepting cycle.
- near and range are sampled at accept only.

Test Plan:
- Lossless regular: near=0, range=256, Px=100, C=5, sign=0, x=110 → x_residual=5; out_valid first high after E+2; in_ready low during PRED, MOD and OUT.
- Negated correction plus modulo wrap:
  - Px=100, C=5, sign=1, x=90 → 5.
  - Then Px=10, C=0, sign=0, x=250 → e=240, reduced to -16; x_residual = 9'h1F0.
- Clamp: Px=250, C=20, sign=0, x=255 → Pc clamped to 255 → 0. Also Px=3, C=-10, sign=0, x=0 → Pc clamped to 0 → 0.
- Near-lossless: near=2, range=52.
  - Px=100, C=0, x=113 → 3, out_valid after E+11.
  - x=87 → -3 (9'h1FD).
- Run interruption: mode=1, Px=50, x=40.
  - RIType=0, a_b_compare=1 → 10.
  - RIType=1, a_b_compare=1 → -10 (9'h1F6).
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in OUT → x_residual and out_valid held constant; in_ready stays 0.
  - Assert reset_n=0 during DIV cycle 4 → out_valid=0, in_ready=1 immediately.
  - After release, the next sample (near=0, Px=100, C=5, sign=0, x=110) yields 5.
